// File: rtl/path_delay_monitor.sv
// Clocked observer for a specify-path DUT: times each input change to the resulting output
// change and reports delay, source bit, overlap, timeout and window violation.
module path_delay_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_WAIT = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             dut_out,
  input  logic [CNT_W-1:0] min_lim,
  input  logic [CNT_W-1:0] max_lim,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic [IDX_W-1:0] src_idx,
  output logic             overlap,
  output logic             timeout,
  output logic             violation,
  output logic             spurious,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_PRIME   = 2'd0,
    S_IDLE    = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   in_q;
  logic               out_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]   meas_delay_q, meas_delay_d;
  logic [IDX_W-1:0]   src_idx_q, src_idx_d;
  logic               overlap_q, overlap_d;
  logic               timeout_q, timeout_d;
  logic               violation_q, violation_d;
  logic               spurious_q, spurious_d;
  logic               busy_q, busy_d;

  logic               in_chg;
  logic               out_chg;
  logic               report;
  logic [IDX_W-1:0]   chg_idx;

  // Lowest-index set bit; scanning downward leaves the lowest one last.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign in_chg  = (in_vec != in_q);
  assign out_chg = (dut_out != out_q);
  assign chg_idx = lowest_set(in_vec ^ in_q);

  // Next-state and report-field logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    meas_delay_d = meas_delay_q;
    src_idx_d    = src_idx_q;
    overlap_d    = overlap_q;
    timeout_d    = timeout_q;
    violation_d  = violation_q;
    spurious_d   = 1'b0;
    report       = 1'b0;

    unique case (state_q)
      S_PRIME: begin
        state_d = S_IDLE;
      end
      S_IDLE, S_REPORT: begin
        if (in_chg && out_chg) begin
          src_idx_d    = chg_idx;
          overlap_d    = 1'b0;
          timeout_d    = 1'b0;
          meas_delay_d = '0;
          count_d      = '0;
          report       = 1'b1;
          state_d      = S_REPORT;
        end else if (in_chg) begin
          src_idx_d = chg_idx;
          overlap_d = 1'b0;
          timeout_d = 1'b0;
          count_d   = CNT_W'(1);
          state_d   = S_MEASURE;
        end else if (out_chg) begin
          spurious_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEASURE: begin
        if (in_chg) overlap_d = 1'b1;
        if (out_chg) begin
          meas_delay_d = count_q;
          report       = 1'b1;
          state_d      = S_REPORT;
        end else if (count_q == MAX_CNT) begin
          meas_delay_d = MAX_CNT;
          timeout_d    = 1'b1;
          report       = 1'b1;
          state_d      = S_REPORT;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_PRIME;
      end
    endcase

    // Limits are sampled on the same edge that enters REPORT.
    if (report) begin
      violation_d = timeout_d | (meas_delay_d < min_lim) | (meas_delay_d > max_lim);
    end

    meas_valid_d = report;
    busy_d       = (state_d == S_MEASURE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_PRIME;
      in_q         <= '0;
      out_q        <= 1'b0;
      count_q      <= '0;
      meas_valid_q <= 1'b0;
      meas_delay_q <= '0;
      src_idx_q    <= '0;
      overlap_q    <= 1'b0;
      timeout_q    <= 1'b0;
      violation_q  <= 1'b0;
      spurious_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_q         <= in_vec;
      out_q        <= dut_out;
      count_q      <= count_d;
      meas_valid_q <= meas_valid_d;
      meas_delay_q <= meas_delay_d;
      src_idx_q    <= src_idx_d;
      overlap_q    <= overlap_d;
      timeout_q    <= timeout_d;
      violation_q  <= violation_d;
      spurious_q   <= spurious_d;
      busy_q       <= busy_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign meas_delay = meas_delay_q;
  assign src_idx    = src_idx_q;
  assign overlap    = overlap_q;
  assign timeout    = timeout_q;
  assign violation  = violation_q;
  assign spurious   = spurious_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_path_delay_monitor.sv
// Bench for path_delay_monitor: directed scenarios plus randomized transitions checked
// against expectations derived from the edge-count delay definition.
module tb_path_delay_monitor;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned MAX_WAIT = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_vec;
  logic             dut_out;
  logic [CNT_W-1:0] min_lim;
  logic [CNT_W-1:0] max_lim;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [IDX_W-1:0] src_idx;
  logic             overlap;
  logic             timeout;
  logic             violation;
  logic             spurious;
  logic             busy;

  int total = 0;
  int bad   = 0;

  path_delay_monitor #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock), .reset(reset), .in_vec(in_vec), .dut_out(dut_out),
    .min_lim(min_lim), .max_lim(max_lim), .meas_valid(meas_valid),
    .meas_delay(meas_delay), .src_idx(src_idx), .overlap(overlap),
    .timeout(timeout), .violation(violation), .spurious(spurious), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int lowest_bit(input logic [WIDTH-1:0] m);
    for (int i = 0; i < int'(WIDTH); i++) if (m[i]) return i;
    return 0;
  endfunction

  // Toggle `mask` bits, let the output follow d edges later (never if d > MAX_WAIT), optionally
  // toggle `ovm` bits so their change is sampled ov edges after the start. Leaves the bench just
  // after the edge on which the report should have been registered.
  task automatic drive_meas(input logic [WIDTH-1:0] mask, input int d, input int ov,
                            input logic [WIDTH-1:0] ovm, output int wait_bad);
    int ed;
    ed = (d > int'(MAX_WAIT)) ? int'(MAX_WAIT) : d;
    wait_bad = 0;
    if (d == 0) begin
      in_vec  = in_vec ^ mask;
      dut_out = ~dut_out;
      step();
    end else begin
      in_vec = in_vec ^ mask;
      step();
      if (meas_valid !== 1'b0 || busy !== 1'b1) wait_bad++;
      for (int k = 1; k < ed; k++) begin
        if (k == ov) in_vec = in_vec ^ ovm;
        step();
        if (meas_valid !== 1'b0 || busy !== 1'b1) wait_bad++;
      end
      if (ov == ed) in_vec = in_vec ^ ovm;
      if (d <= int'(MAX_WAIT)) dut_out = ~dut_out;
      step();
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset   = 1'b1;
    in_vec  = 4'b1111;
    dut_out = 1'b1;
    min_lim = 8'd9;
    max_lim = 8'd11;
    step(); step();
    total++;
    if ({meas_valid, meas_delay, src_idx, overlap, timeout, violation, spurious, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {meas_valid, meas_delay, src_idx, overlap, timeout, violation, spurious, busy});
    end
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (meas_valid !== 1'b0 || spurious !== 1'b0 || busy !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_release_quiet got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_basic();
    int wb;
    min_lim = 8'd9;
    max_lim = 8'd11;
    drive_meas(4'b0001, 9, 0, 4'b0000, wb);   // 1111 -> 1110, out 1 -> 0
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd9 || src_idx !== 2'd0 || violation !== 1'b0 || wb != 0) begin
      bad++;
      $display("FAIL t2_report got v=%0b d=%0d s=%0d viol=%0b wb=%0d exp v=1 d=9 s=0 viol=0 wb=0",
               meas_valid, meas_delay, src_idx, violation, wb);
    end
    step();
    total++;
    if (meas_valid !== 1'b0 || meas_delay !== 8'd9) begin
      bad++;
      $display("FAIL t2_hold got v=%0b d=%0d exp v=0 d=9", meas_valid, meas_delay);
    end
    drive_meas(4'b1000, 11, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd11 || src_idx !== 2'd3 || violation !== 1'b0) begin
      bad++;
      $display("FAIL t3_in_window got v=%0b d=%0d s=%0d viol=%0b exp v=1 d=11 s=3 viol=0",
               meas_valid, meas_delay, src_idx, violation);
    end
    step();
    drive_meas(4'b1000, 12, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd12 || src_idx !== 2'd3 || violation !== 1'b1) begin
      bad++;
      $display("FAIL t3_over_max got v=%0b d=%0d s=%0d viol=%0b exp v=1 d=12 s=3 viol=1",
               meas_valid, meas_delay, src_idx, violation);
    end
    step();
  endtask

  task automatic test_timeout();
    int wb;
    min_lim = 8'd9;
    max_lim = 8'd11;
    drive_meas(4'b0010, 99, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd32 || timeout !== 1'b1 || violation !== 1'b1 || src_idx !== 2'd1 || wb != 0) begin
      bad++;
      $display("FAIL t4_timeout got v=%0b d=%0d to=%0b viol=%0b s=%0d wb=%0d exp v=1 d=32 to=1 viol=1 s=1 wb=0",
               meas_valid, meas_delay, timeout, violation, src_idx, wb);
    end
    step();
    min_lim = 8'd0;
    max_lim = 8'd40;
    drive_meas(4'b0100, 32, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd32 || timeout !== 1'b0 || violation !== 1'b0) begin
      bad++;
      $display("FAIL t4_edge_32 got v=%0b d=%0d to=%0b viol=%0b exp v=1 d=32 to=0 viol=0",
               meas_valid, meas_delay, timeout, violation);
    end
    step();
  endtask

  task automatic test_overlap();
    int wb;
    min_lim = 8'd9;
    max_lim = 8'd11;
    drive_meas(4'b0001, 9, 3, 4'b0100, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd9 || src_idx !== 2'd0 || overlap !== 1'b1 || violation !== 1'b0) begin
      bad++;
      $display("FAIL t5_overlap got v=%0b d=%0d s=%0d ov=%0b viol=%0b exp v=1 d=9 s=0 ov=1 viol=0",
               meas_valid, meas_delay, src_idx, overlap, violation);
    end
    step();
    drive_meas(4'b0110, 10, 0, 4'b0000, wb);
    total++;
    if (overlap !== 1'b0 || src_idx !== 2'd1 || meas_delay !== 8'd10) begin
      bad++;
      $display("FAIL t5_overlap_clear got ov=%0b s=%0d d=%0d exp ov=0 s=1 d=10", overlap, src_idx, meas_delay);
    end
    step();
  endtask

  task automatic test_spurious();
    dut_out = ~dut_out;
    step();
    total++;
    if (spurious !== 1'b1 || meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL t6_spurious got sp=%0b v=%0b exp sp=1 v=0", spurious, meas_valid);
    end
    step();
    total++;
    if (spurious !== 1'b0) begin
      bad++;
      $display("FAIL t6_spurious_once got sp=%0b exp sp=0", spurious);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    in_vec = in_vec ^ 4'b1000;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL t6_busy got=%0b exp=1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({meas_valid, meas_delay, src_idx, overlap, timeout, violation, spurious, busy} !== '0) begin
      bad++;
      $display("FAIL t6_async_reset got=%0h exp=0",
               {meas_valid, meas_delay, src_idx, overlap, timeout, violation, spurious, busy});
    end
    step();
    in_vec  = 4'b1011;
    dut_out = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (meas_valid !== 1'b0 || spurious !== 1'b0 || busy !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL t6_abandoned got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int wb;
    min_lim = 8'd4;
    max_lim = 8'd6;
    drive_meas(4'b0100, 5, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd5 || src_idx !== 2'd2 || violation !== 1'b0) begin
      bad++;
      $display("FAIL t7_first got v=%0b d=%0d s=%0d viol=%0b exp v=1 d=5 s=2 viol=0",
               meas_valid, meas_delay, src_idx, violation);
    end
    drive_meas(4'b0011, 3, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd3 || src_idx !== 2'd0 || violation !== 1'b1 || wb != 0) begin
      bad++;
      $display("FAIL t7_second got v=%0b d=%0d s=%0d viol=%0b wb=%0d exp v=1 d=3 s=0 viol=1 wb=0",
               meas_valid, meas_delay, src_idx, violation, wb);
    end
    drive_meas(4'b1000, 0, 0, 4'b0000, wb);
    total++;
    if (meas_valid !== 1'b1 || meas_delay !== 8'd0 || src_idx !== 2'd3 || violation !== 1'b1 || overlap !== 1'b0) begin
      bad++;
      $display("FAIL t7_zero got v=%0b d=%0d s=%0d viol=%0b ov=%0b exp v=1 d=0 s=3 viol=1 ov=0",
               meas_valid, meas_delay, src_idx, violation, overlap);
    end
    step();
  endtask

  task automatic test_random();
    int wb, d, ov, ed, lo, hi;
    logic [WIDTH-1:0] mask, ovm;
    logic e_to, e_ov, e_viol;
    for (int n = 0; n < 30; n++) begin
      mask = WIDTH'($urandom_range(1, 15));
      ovm  = WIDTH'($urandom_range(1, 15));
      d    = int'($urandom_range(0, 36));
      ed   = (d > int'(MAX_WAIT)) ? int'(MAX_WAIT) : d;
      ov   = (d == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, ed));
      lo   = int'($urandom_range(0, 20));
      hi   = lo + int'($urandom_range(0, 15));
      min_lim = CNT_W'(lo);
      max_lim = CNT_W'(hi);
      e_to   = (d > int'(MAX_WAIT));
      e_ov   = (ov != 0);
      e_viol = e_to || (ed < lo) || (ed > hi);
      drive_meas(mask, d, ov, ovm, wb);
      total++;
      if (meas_valid !== 1'b1 || meas_delay !== CNT_W'(ed) || src_idx !== IDX_W'(lowest_bit(mask)) ||
          overlap !== e_ov || timeout !== e_to || violation !== e_viol || busy !== 1'b0 || wb != 0) begin
        bad++;
        $display("FAIL rnd%0d got v=%0b d=%0d s=%0d ov=%0b to=%0b viol=%0b busy=%0b wb=%0d exp v=1 d=%0d s=%0d ov=%0b to=%0b viol=%0b busy=0 wb=0",
                 n, meas_valid, meas_delay, src_idx, overlap, timeout, violation, busy, wb,
                 ed, lowest_bit(mask), e_ov, e_to, e_viol);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overlap();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
